// File: rtl/conv_axi_rd_master.sv
// conv_axi_rd_master
// AXI4 read master that feeds one conv engine input stream (IFM or WGT buffer).
// A one-cycle rmst_req starts a read of xfer_size bytes from addr_base+addr_offset,
// split into INCR bursts that never cross a 4 KB page. Returned beats are passed
// straight through to the AXI stream; rmst_done pulses once the final beat has been
// accepted downstream.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rmst_req          start pulse (ignored while busy)
//   addr_base/offset  region base + byte offset (sum is 64 B aligned)
//   xfer_size         bytes to read (multiple of 64)
//   rmst_done         one-cycle completion pulse
//   busy              transfer in progress
//   rresp_err         sticky error flag for the current transfer
//   m_axi_ar*         AXI read address channel
//   m_axi_r*          AXI read data channel
//   axis_t*           output stream (combinational pass-through of R)
module conv_axi_rd_master #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int BURST_LEN  = 64,
    parameter int MAX_OUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rmst_req,
    input  logic [ADDR_WIDTH-1:0] addr_base,
    input  logic [ADDR_WIDTH-1:0] addr_offset,
    input  logic [ADDR_WIDTH-1:0] xfer_size,
    output logic                  rmst_done,
    output logic                  busy,
    output logic                  rresp_err,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                  m_axi_rlast,
    input  logic [1:0]            m_axi_rresp,
    output logic                  axis_tvalid,
    input  logic                  axis_tready,
    output logic [DATA_WIDTH-1:0] axis_tdata
);

    localparam int CNT_W = ADDR_WIDTH - 6;          // beat counters (64 B per beat)
    localparam int OUT_W = $clog2(MAX_OUT) + 1;     // holds 0..MAX_OUT

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q,  cur_addr_d;
    logic [CNT_W-1:0]      ar_beats_q,  ar_beats_d;
    logic [CNT_W-1:0]      r_beats_q,   r_beats_d;
    logic [OUT_W-1:0]      out_q,       out_d;
    logic                  arvalid_q,   arvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_q,    araddr_d;
    logic [7:0]            arlen_q,     arlen_d;
    logic [8:0]            len_q,       len_d;
    logic                  rresp_err_q, rresp_err_d;

    logic [6:0]       page_beats;
    logic [CNT_W-1:0] len_w;
    logic [8:0]       len_c;
    logic             ar_hs;
    logic             beat_acc;
    logic             rlast_acc;
    logic             unused_size_bits;

    // Low size bits are always zero for a legal request.
    assign unused_size_bits = ^xfer_size[5:0];

    // R channel is a zero-latency pass-through.
    assign m_axi_rready = axis_tready;
    assign axis_tvalid  = m_axi_rvalid;
    assign axis_tdata   = m_axi_rdata;

    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign busy          = (state_q != S_IDLE);
    assign rmst_done     = (state_q == S_DONE);
    assign rresp_err     = rresp_err_q;

    assign ar_hs     = arvalid_q & m_axi_arready;
    assign beat_acc  = (state_q == S_RUN) & m_axi_rvalid & axis_tready;
    assign rlast_acc = beat_acc & m_axi_rlast;

    // Burst length: limited by BURST_LEN, remaining beats and distance to the
    // next 4 KB boundary (address is 64 B aligned so bits [11:6] give the beat slot).
    always_comb begin
        page_beats = 7'd64 - {1'b0, cur_addr_q[11:6]};
        len_w      = ar_beats_q;
        if (len_w > CNT_W'(BURST_LEN)) begin
            len_w = CNT_W'(BURST_LEN);
        end
        if (len_w > CNT_W'(page_beats)) begin
            len_w = CNT_W'(page_beats);
        end
        len_c = 9'(len_w);
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        ar_beats_d  = ar_beats_q;
        r_beats_d   = r_beats_q;
        out_d       = out_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        len_d       = len_q;
        rresp_err_d = rresp_err_q;

        case (state_q)
            S_IDLE: begin
                if (rmst_req) begin
                    state_d     = S_LOAD;
                    cur_addr_d  = addr_base + addr_offset;
                    ar_beats_d  = xfer_size[ADDR_WIDTH-1:6];
                    r_beats_d   = xfer_size[ADDR_WIDTH-1:6];
                    out_d       = '0;
                    rresp_err_d = 1'b0;
                end
            end
            S_LOAD: begin
                state_d = (r_beats_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                // A new AR is raised only from an idle AR channel, so address and
                // length stay frozen while the slave stalls, and back-to-back
                // requests are separated by at least one cycle.
                if (!arvalid_q && (ar_beats_q != '0) && (out_q < OUT_W'(MAX_OUT))) begin
                    arvalid_d = 1'b1;
                    araddr_d  = cur_addr_q;
                    arlen_d   = 8'(len_c - 9'd1);
                    len_d     = len_c;
                end
                if (ar_hs) begin
                    arvalid_d  = 1'b0;
                    cur_addr_d = cur_addr_q + (ADDR_WIDTH'(len_q) << 6);
                    ar_beats_d = ar_beats_q - CNT_W'(len_q);
                end
                // Simultaneous AR handshake and burst completion cancel out.
                case ({ar_hs, rlast_acc})
                    2'b10:   out_d = out_q + OUT_W'(1);
                    2'b01:   out_d = out_q - OUT_W'(1);
                    default: out_d = out_q;
                endcase
                if (beat_acc) begin
                    r_beats_d = r_beats_q - CNT_W'(1);
                    if (m_axi_rresp != 2'b00) begin
                        rresp_err_d = 1'b1;
                    end
                    if (r_beats_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            ar_beats_q  <= '0;
            r_beats_q   <= '0;
            out_q       <= '0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            len_q       <= '0;
            rresp_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            ar_beats_q  <= ar_beats_d;
            r_beats_q   <= r_beats_d;
            out_q       <= out_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            len_q       <= len_d;
            rresp_err_q <= rresp_err_d;
        end
    end

    // A last beat with no burst outstanding means the slave misbehaved.
    always_ff @(posedge clk) begin
        if (!rst && rlast_acc) begin
            assert (out_q != '0);
        end
    end

endmodule

// File: tb/tb_conv_axi_rd_master.sv
module tb_conv_axi_rd_master;

    logic          clk;
    logic          rst;
    logic          rmst_req;
    logic [63:0]   addr_base;
    logic [63:0]   addr_offset;
    logic [63:0]   xfer_size;
    logic          rmst_done;
    logic          busy;
    logic          rresp_err;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [63:0]   m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [511:0]  m_axi_rdata;
    logic          m_axi_rlast;
    logic [1:0]    m_axi_rresp;
    logic          axis_tvalid;
    logic          axis_tready;
    logic [511:0]  axis_tdata;

    conv_axi_rd_master #(
        .ADDR_WIDTH(64), .DATA_WIDTH(512), .BURST_LEN(64), .MAX_OUT(4)
    ) dut (
        .clk(clk), .rst(rst), .rmst_req(rmst_req),
        .addr_base(addr_base), .addr_offset(addr_offset), .xfer_size(xfer_size),
        .rmst_done(rmst_done), .busy(busy), .rresp_err(rresp_err),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast), .m_axi_rresp(m_axi_rresp),
        .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tdata(axis_tdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Written only by the main sequence
    logic [63:0] exp_base;
    int          base_beats;
    int          err_at;
    logic        r_en, ar_on, ar_rand, tr_rand, rv_rand;
    int          ar0, done0;

    // Written only by the slave/monitor process
    logic [63:0] q_addr [$];
    logic [7:0]  q_len [$];
    logic [63:0] ar_a [64];
    logic [7:0]  ar_l [64];
    int          ar_n = 0;
    int          sb_beats = 0;
    int          done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input logic [63:0] b, input logic [63:0] o, input logic [63:0] s);
        exp_base    = b + o;
        base_beats  = sb_beats;
        ar0         = ar_n;
        done0       = done_cnt;
        addr_base   = b;
        addr_offset = o;
        xfer_size   = s;
        rmst_req    = 1'b1;
        tick();
        rmst_req    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == done0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(done_cnt != done0), 64'd1);
    endtask

    // AXI slave model and stream monitor
    initial begin
        logic        acc;
        logic        pend;
        logic [63:0] pend_addr;
        logic [7:0]  pend_len;
        logic [63:0] ea;
        int          bidx;
        acc = 1'b0; pend = 1'b0; pend_addr = '0; pend_len = '0; bidx = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; axis_tready = 1'b0;
        forever begin
            @(negedge clk);
            acc = m_axi_rvalid && axis_tready;
            if (!rst) begin
                chk("rready_eq_tready", 64'(m_axi_rready), 64'(axis_tready));
                chk("tvalid_eq_rvalid", 64'(axis_tvalid), 64'(m_axi_rvalid));
                if (pend) begin
                    chk("ar_hold_valid", 64'(m_axi_arvalid), 64'd1);
                    chk("ar_hold_addr", m_axi_araddr, pend_addr);
                    chk("ar_hold_len", 64'(m_axi_arlen), 64'(pend_len));
                end
                pend      = m_axi_arvalid && !m_axi_arready;
                pend_addr = m_axi_araddr;
                pend_len  = m_axi_arlen;
                if (rmst_done) done_cnt++;
                if (m_axi_arvalid && m_axi_arready) begin
                    q_addr.push_back(m_axi_araddr);
                    q_len.push_back(m_axi_arlen);
                    if (ar_n < 64) begin
                        ar_a[ar_n] = m_axi_araddr;
                        ar_l[ar_n] = m_axi_arlen;
                    end
                    ar_n++;
                end
                if (acc) begin
                    ea = exp_base + 64'(sb_beats - base_beats) * 64'd64;
                    checks++;
                    assert (axis_tdata === {8{ea}}) else begin
                        errors++;
                        $error("FAIL tdata observed=%0h expected=%0h", axis_tdata[63:0], ea);
                    end
                    sb_beats++;
                    if (m_axi_rlast && q_len.size() > 0) begin
                        void'(q_addr.pop_front());
                        void'(q_len.pop_front());
                        bidx = 0;
                    end else begin
                        bidx++;
                    end
                end
                chk("outstanding_le_4", 64'(q_len.size() <= 4), 64'd1);
            end else begin
                pend = 1'b0;
            end
            @(posedge clk);
            #1;
            if (rst) begin
                q_addr.delete();
                q_len.delete();
                bidx = 0;
                m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
                m_axi_arready = 1'b0; axis_tready = 1'b0;
            end else begin
                m_axi_arready = ar_rand ? 1'($urandom_range(0, 1)) : ar_on;
                axis_tready   = tr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!(m_axi_rvalid && !acc)) begin
                    if (q_len.size() > 0 && r_en && (!rv_rand || $urandom_range(0, 1) == 1)) begin
                        ea           = q_addr[0] + 64'(bidx) * 64'd64;
                        m_axi_rvalid = 1'b1;
                        m_axi_rdata  = {8{ea}};
                        m_axi_rlast  = (bidx == int'(q_len[0]));
                        m_axi_rresp  = (sb_beats == err_at) ? 2'd2 : 2'd0;
                    end else begin
                        m_axi_rvalid = 1'b0;
                        m_axi_rlast  = 1'b0;
                        m_axi_rresp  = 2'b00;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rmst_req = 1'b0;
        addr_base = '0; addr_offset = '0; xfer_size = '0;
        r_en = 1'b1; ar_on = 1'b1; ar_rand = 1'b0; tr_rand = 1'b0; rv_rand = 1'b0;
        err_at = -1; exp_base = '0; base_beats = 0; ar0 = 0; done0 = 0;
        repeat (3) tick();
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_araddr", m_axi_araddr, 64'd0);
        chk("rst_arlen", 64'(m_axi_arlen), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(rmst_done), 64'd0);
        chk("rst_rresp_err", 64'(rresp_err), 64'd0);
        rst = 1'b0;
        tick();

        // 1) two full 4 KB bursts
        start(64'h1000, 64'h0, 64'd8192);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done("t1_done_timeout", 2000);
        repeat (3) tick();
        chk("t1_ar_count", 64'(ar_n - ar0), 64'd2);
        chk("t1_ar0_addr", ar_a[ar0], 64'h1000);
        chk("t1_ar0_len", 64'(ar_l[ar0]), 64'd63);
        chk("t1_ar1_addr", ar_a[ar0 + 1], 64'h2000);
        chk("t1_ar1_len", 64'(ar_l[ar0 + 1]), 64'd63);
        chk("t1_beats", 64'(sb_beats - base_beats), 64'd128);
        chk("t1_done_pulses", 64'(done_cnt - done0), 64'd1);
        chk("t1_busy_after", 64'(busy), 64'd0);

        // 2) split at the 4 KB boundary
        start(64'h0F80, 64'h0, 64'd512);
        wait_done("t2_done_timeout", 500);
        repeat (3) tick();
        chk("t2_ar_count", 64'(ar_n - ar0), 64'd2);
        chk("t2_ar0_addr", ar_a[ar0], 64'h0F80);
        chk("t2_ar0_len", 64'(ar_l[ar0]), 64'd1);
        chk("t2_ar1_addr", ar_a[ar0 + 1], 64'h1000);
        chk("t2_ar1_len", 64'(ar_l[ar0 + 1]), 64'd5);
        chk("t2_beats", 64'(sb_beats - base_beats), 64'd8);

        // 3) zero-length transfer: done two cycles after req, no AR
        start(64'h3000, 64'h0, 64'd0);
        chk("t3_busy_load", 64'(busy), 64'd1);
        chk("t3_done_early", 64'(rmst_done), 64'd0);
        tick();
        chk("t3_done_pulse", 64'(rmst_done), 64'd1);
        tick();
        chk("t3_done_clear", 64'(rmst_done), 64'd0);
        chk("t3_busy_clear", 64'(busy), 64'd0);
        chk("t3_ar_count", 64'(ar_n - ar0), 64'd0);

        // 4) outstanding limit with R channel stalled
        r_en = 1'b0;
        start(64'h10000, 64'h0, 64'd24576);
        repeat (30) tick();
        chk("t4_ar_capped", 64'(ar_n - ar0), 64'd4);
        chk("t4_arvalid_low", 64'(m_axi_arvalid), 64'd0);
        chk("t4_busy", 64'(busy), 64'd1);
        r_en = 1'b1;
        wait_done("t4_done_timeout", 3000);
        repeat (3) tick();
        chk("t4_ar_total", 64'(ar_n - ar0), 64'd6);
        chk("t4_beats", 64'(sb_beats - base_beats), 64'd384);
        chk("t4_done_pulses", 64'(done_cnt - done0), 64'd1);

        // 5) random handshakes on every channel
        ar_rand = 1'b1; tr_rand = 1'b1; rv_rand = 1'b1;
        start(64'h20040, 64'h40, 64'd12288);
        wait_done("t5_done_timeout", 8000);
        ar_rand = 1'b0; tr_rand = 1'b0; rv_rand = 1'b0;
        repeat (3) tick();
        chk("t5_beats", 64'(sb_beats - base_beats), 64'd192);
        chk("t5_ar_count", 64'(ar_n - ar0), 64'd4);
        chk("t5_ar0_len", 64'(ar_l[ar0]), 64'd61);
        chk("t5_done_pulses", 64'(done_cnt - done0), 64'd1);

        // 6) error response on beat 5, sticky until next request
        err_at = sb_beats + 5;
        start(64'h30000, 64'h0, 64'd640);
        wait_done("t6_done_timeout", 500);
        err_at = -1;
        repeat (3) tick();
        chk("t6_rresp_err", 64'(rresp_err), 64'd1);
        chk("t6_beats", 64'(sb_beats - base_beats), 64'd10);
        chk("t6_done_pulses", 64'(done_cnt - done0), 64'd1);
        start(64'h40000, 64'h0, 64'd64);
        chk("t6_err_cleared", 64'(rresp_err), 64'd0);
        wait_done("t6b_done_timeout", 200);
        repeat (2) tick();
        chk("t6b_rresp_err", 64'(rresp_err), 64'd0);

        // reset in the middle of a transfer
        start(64'h50000, 64'h0, 64'd8192);
        repeat (20) tick();
        chk("rstmid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        chk("rstmid_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rstmid_araddr", m_axi_araddr, 64'd0);
        chk("rstmid_arlen", 64'(m_axi_arlen), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_done", 64'(rmst_done), 64'd0);
        chk("rstmid_rresp_err", 64'(rresp_err), 64'd0);
        chk("rstmid_tvalid", 64'(axis_tvalid), 64'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
